fetch_unit: RTL and testbench

//  Instruction-fetch stage; sits directly upstream of the instruction memory.

---
 rtl/fetch_unit_if.sv | 34 +++
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus bundle: imem address/data and decode valid/ready handshake
//   master (fetch_unit): drives imem_addr, instr_o, pc_o, pc_plus4_o, valid_o; samples imem_instr, ready_i
//   slave  (memory/decode side): drives imem_instr, ready_i; samples the rest
interface fetch_unit_if #(
    parameter int N = 32
);
    logic [N-1:0] imem_addr;
    logic [N-1:0] imem_instr;
    logic [N-1:0] instr_o;
    logic [N-1:0] pc_o;
    logic [N-1:0] pc_plus4_o;
    logic         valid_o;
    logic         ready_i;

    modport master (
        output imem_addr,
        output instr_o,
        output pc_o,
        output pc_plus4_o,
        output valid_o,
        input  imem_instr,
        input  ready_i
    );

    modport slave (
        input  imem_addr,
        input  instr_o,
        input  pc_o,
        input  pc_plus4_o,
        input  valid_o,
        output imem_instr,
        output ready_i
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem address, output register, redirect/halt/fault
//   clk, rstn       : clock, synchronous active-low reset
//   bus (master)    : imem_addr/imem_instr to memory, instr_o/pc_o/pc_plus4_o/valid_o/ready_i to decode
//   redirect, redirect_pc : flush and load a new PC
//   halt            : stop issuing fetches while high
//   fault_o         : sticky misaligned / out-of-range PC flag
//   FETCH_PERF_CNT_EN : when defined, adds fetch_cnt and stall_cnt outputs
module fetch_unit #(
    parameter int           N          = 32,
    parameter logic [N-1:0] RESET_PC   = '0,
    parameter int           IMEM_BYTES = 256
) (
    input  logic          clk,
    input  logic          rstn,
    fetch_unit_if.master  bus,
    input  logic          redirect,
    input  logic [N-1:0]  redirect_pc,
    input  logic          halt,
    output logic          fault_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   fetch_cnt,
    output logic [31:0]   stall_cnt
`endif
);
    // Highest byte address at which a whole word still fits in memory.
    localparam logic [N-1:0] LAST_WORD = N'(IMEM_BYTES - 4);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_HALT,
        ST_FAULT
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic [N-1:0] instr_q, instr_d;
    logic [N-1:0] pco_q, pco_d;
    logic [N-1:0] pc4_q, pc4_d;
    logic         valid_q, valid_d;
    logic         fault_q, fault_d;
    logic         pc_ok;
    logic         fire;

    assign bus.imem_addr  = pc_q;
    assign bus.instr_o    = instr_q;
    assign bus.pc_o       = pco_q;
    assign bus.pc_plus4_o = pc4_q;
    assign bus.valid_o    = valid_q;
    assign fault_o        = fault_q;

    assign pc_ok = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_WORD);
    // A fetch only happens when the output register is free or being emptied this cycle.
    assign fire  = (state_q == ST_FETCH) && !halt && !redirect
                   && (!valid_q || bus.ready_i) && pc_ok;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pco_d   = pco_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        fault_d = fault_q;

        if (redirect) begin
            // Discard whatever is held, even if decode is taking it this cycle.
            state_d = ST_FETCH;
            pc_d    = redirect_pc;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_BOOT:  state_d = ST_FETCH;
                ST_FETCH: begin
                    if (halt) begin
                        state_d = ST_HALT;
                    end else if (!pc_ok) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end
                end
                ST_HALT:  if (!halt) state_d = ST_FETCH;
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_BOOT;
            endcase

            if (fire) begin
                instr_d = bus.imem_instr;
                pco_d   = pc_q;
                pc4_d   = pc_q + N'(4);
                pc_d    = pc_q + N'(4);
                valid_d = 1'b1;
            end else if (valid_q && bus.ready_i) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            pco_q   <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pco_q   <= pco_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (fire) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (valid_q && !bus.ready_i) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit: directed scenarios plus randomized run against a model
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rstn;
    logic        ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        fault_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    bit          done    = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A_1234;
    endfunction

    fetch_unit_if #(.N(32)) bus ();
    assign bus.imem_instr = mem_word(bus.imem_addr);
    assign bus.ready_i    = ready;

    fetch_unit #(.N(32), .RESET_PC(32'h0), .IMEM_BYTES(256)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .fault_o     (fault_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: tracks what the stage holds and where it will fetch next.
    logic [31:0] m_pc, m_instr, m_pco, m_pc4;
    bit          m_valid, m_fault, m_boot, m_halted, m_faulted, m_live = 0;
    int unsigned m_fetch, m_stall;

    always @(posedge clk) begin
        bit ok;
        bit take;
        if (!rstn) begin
            m_pc = 32'h0; m_instr = 0; m_pco = 0; m_pc4 = 0;
            m_valid = 0; m_fault = 0; m_boot = 1; m_halted = 0; m_faulted = 0;
            m_fetch = 0; m_stall = 0; m_live = 1;
        end else if (m_live) begin
            ok   = (m_pc % 4 == 0) && (m_pc <= 32'd252);
            take = !m_boot && !m_halted && !m_faulted && !halt && !redirect
                   && (!m_valid || ready) && ok;
            if (m_valid && !ready) m_stall++;
            if (take) m_fetch++;
            if (redirect) begin
                m_valid = 0; m_pc = redirect_pc;
                m_boot = 0; m_halted = 0; m_faulted = 0;
            end else begin
                if (take) begin
                    m_instr = mem_word(m_pc); m_pco = m_pc; m_pc4 = m_pc + 4;
                    m_pc = m_pc + 4; m_valid = 1;
                end else if (m_valid && ready) begin
                    m_valid = 0;
                end
                if (m_boot) m_boot = 0;
                else if (m_halted) m_halted = halt;
                else if (!m_faulted) begin
                    if (halt) m_halted = 1;
                    else if (!ok) begin m_faulted = 1; m_fault = 1; end
                end
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (m_live && !done) begin
            check("imem_addr", bus.imem_addr, m_pc);
            check("valid_o", 32'(bus.valid_o), 32'(m_valid));
            check("fault_o", 32'(fault_o), 32'(m_fault));
            if (m_valid) begin
                check("instr_o", bus.instr_o, m_instr);
                check("pc_o", bus.pc_o, m_pco);
                check("pc_plus4_o", bus.pc_plus4_o, m_pc4);
            end
`ifdef FETCH_PERF_CNT_EN
            check("fetch_cnt", fetch_cnt, m_fetch);
            check("stall_cnt", stall_cnt, m_stall);
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0; redirect = 1'b0; halt = 1'b0; ready = 1'b1; redirect_pc = '0;
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        bit got;
        rstn = 1'b0; ready = 1'b1; redirect = 1'b0; halt = 1'b0; redirect_pc = '0;
        tick(); tick();
        rstn = 1'b1;
        check("reset valid_o", 32'(bus.valid_o), 32'd0);
        check("reset fault_o", 32'(fault_o), 32'd0);
        check("reset pc_o", bus.pc_o, 32'h0);
        check("reset pc_plus4_o", bus.pc_plus4_o, 32'h0);

        // Sequential fetch after boot
        tick(); check("boot valid_o", 32'(bus.valid_o), 32'd0);
        tick(); check("seq valid", 32'(bus.valid_o), 32'd1); check("seq pc 0", bus.pc_o, 32'h0);
        tick(); check("seq pc 4", bus.pc_o, 32'h4);
        tick(); check("seq pc 8", bus.pc_o, 32'h8); check("seq addr 12", bus.imem_addr, 32'hC);

        // Stall for three cycles at pc_o=8
        ready = 1'b0;
        repeat (3) begin
            tick();
            check("stall pc_o", bus.pc_o, 32'h8);
            check("stall instr", bus.instr_o, mem_word(32'h8));
            check("stall addr", bus.imem_addr, 32'hC);
        end
        ready = 1'b1;
        tick(); check("after stall pc_o", bus.pc_o, 32'hC);

        // Redirect while valid and accepted
        redirect = 1'b1; redirect_pc = 32'h40;
        tick(); check("redir valid_o", 32'(bus.valid_o), 32'd0); check("redir addr", bus.imem_addr, 32'h40);
        redirect = 1'b0;
        tick(); check("redir tgt valid", 32'(bus.valid_o), 32'd1);
        check("redir pc_o", bus.pc_o, 32'h40); check("redir pc4", bus.pc_plus4_o, 32'h44);

        // Run off the end of memory
        redirect = 1'b1; redirect_pc = 32'hF0;
        tick(); redirect = 1'b0;
        repeat (4) tick();
        check("end pc_o FC", bus.pc_o, 32'hFC); check("end valid", 32'(bus.valid_o), 32'd1);
        tick();
        check("oob fault", 32'(fault_o), 32'd1); check("oob valid", 32'(bus.valid_o), 32'd0);
        check("oob addr", bus.imem_addr, 32'h100);
        tick(); check("oob still idle", 32'(bus.valid_o), 32'd0);
        redirect = 1'b1; redirect_pc = 32'h0;
        tick(); redirect = 1'b0;
        tick(); check("resume pc_o", bus.pc_o, 32'h0); check("resume valid", 32'(bus.valid_o), 32'd1);
        check("fault sticky", 32'(fault_o), 32'd1);

        // Misaligned redirect target
        do_reset(); tick();
        redirect = 1'b1; redirect_pc = 32'h42;
        tick(); redirect = 1'b0;
        tick(); check("mis fault", 32'(fault_o), 32'd1); check("mis valid", 32'(bus.valid_o), 32'd0);
        tick(); check("mis addr held", bus.imem_addr, 32'h42);

        // Halt with a held instruction
        do_reset(); tick(); tick(); tick();
        check("halt pre pc_o", bus.pc_o, 32'h4);
        ready = 1'b0; halt = 1'b1;
        repeat (3) begin
            tick(); check("halt held pc_o", bus.pc_o, 32'h4); check("halt held valid", 32'(bus.valid_o), 32'd1);
        end
        ready = 1'b1;
        tick(); check("halt drained", 32'(bus.valid_o), 32'd0);
        tick(); check("halt idle", 32'(bus.valid_o), 32'd0);
        halt = 1'b0;
        got = 0;
        for (int i = 0; i < 4 && !got; i++) begin
            tick();
            got = bus.valid_o;
        end
        check("halt resume seen", 32'(got), 32'd1);
        check("halt resume pc_o", bus.pc_o, 32'h8);
`ifdef FETCH_PERF_CNT_EN
        check("stall_cnt literal", stall_cnt, 32'd3);
        check("fetch_cnt literal", fetch_cnt, 32'd3);
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rstn     = ($urandom_range(0, 399) != 0);
            ready    = ($urandom_range(0, 9) < 7);
            redirect = ($urandom_range(0, 15) == 0);
            redirect_pc = 32'($urandom_range(0, 72)) * 32'd4;
            if ($urandom_range(0, 7) == 0) redirect_pc = redirect_pc + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) halt = !halt;
            tick();
        end

        done = 1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
